// File: rtl/uart_tx_block_serializer.sv
// uart_tx_block_serializer
//
// Upstream feeder for the UART transmitter. Takes one N_BLOCK_BITS-wide block
// over a valid/ready handshake, holds it, and offers it to the transmitter
// N_DATA_BITS at a time, most significant byte first.
//
// Ports:
//   i_uart_clk       system clock, shared with the transmitter
//   i_uart_reset     synchronous active-high reset (not gated by i_uart_en)
//   i_uart_en        baud enable, same strobe as the transmitter's enable
//   i_blk_valid      upstream block valid
//   i_blk_data       upstream block, byte 0 in the top N_DATA_BITS
//   o_blk_ready      serializer can accept a block (IDLE only)
//   i_tx_ready       transmitter ready
//   o_tx_data_valid  byte valid to the transmitter
//   o_tx_data        byte currently offered
//   o_busy           a block is held or being sent
//   o_byte_idx       index of the byte currently offered
//   o_blk_done       one-cycle pulse after the last byte is accepted
module uart_tx_block_serializer #(
    parameter int N_BLOCK_BITS = 128,
    parameter int N_DATA_BITS  = 8,
    localparam int N_BYTES     = N_BLOCK_BITS / N_DATA_BITS,
    localparam int CNT_WIDTH   = $clog2(N_BYTES + 1)
) (
    input  logic                    i_uart_clk,
    input  logic                    i_uart_reset,
    input  logic                    i_uart_en,
    input  logic                    i_blk_valid,
    input  logic [N_BLOCK_BITS-1:0] i_blk_data,
    output logic                    o_blk_ready,
    input  logic                    i_tx_ready,
    output logic                    o_tx_data_valid,
    output logic [N_DATA_BITS-1:0]  o_tx_data,
    output logic                    o_busy,
    output logic [CNT_WIDTH-1:0]    o_byte_idx,
    output logic                    o_blk_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [N_BLOCK_BITS-1:0] shreg, shreg_nxt;
    logic [CNT_WIDTH-1:0]    byte_idx, byte_idx_nxt;

    always_ff @(posedge i_uart_clk) begin
        if (i_uart_reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            byte_idx <= '0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            byte_idx <= byte_idx_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        shreg_nxt       = shreg;
        byte_idx_nxt    = byte_idx;
        o_blk_ready     = 1'b0;
        o_busy          = 1'b1;
        o_tx_data_valid = 1'b0;
        o_blk_done      = 1'b0;

        case (state)
            S_IDLE: begin
                o_blk_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_blk_valid) begin
                    shreg_nxt    = i_blk_data;
                    byte_idx_nxt = '0;
                    state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                o_tx_data_valid = 1'b1;
                // Transmitter latches on the same enabled edge this fires on.
                if (i_uart_en && i_tx_ready) begin
                    if (byte_idx < LAST_IDX) begin
                        shreg_nxt    = shreg << N_DATA_BITS;
                        byte_idx_nxt = byte_idx + 1'b1;
                        state_nxt    = S_WAIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                // Hold off until the transmitter's ready is seen low on an
                // enabled cycle, so a stale ready cannot take the next byte.
                if (i_uart_en && !i_tx_ready) begin
                    state_nxt = S_SEND;
                end
            end
            S_DONE: begin
                o_blk_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_tx_data  = shreg[N_BLOCK_BITS-1 -: N_DATA_BITS];
    assign o_byte_idx = byte_idx;

endmodule
